hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/legv8_pkg.sv | 17 +
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl_forward_sel.sv | 24 ++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline constants: forwarding mux codes, the zero register
// and the hazard FSM state encoding.
package legv8_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_WB  = 2'b01;  // operand from Result_W
   localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUResult_M

   localparam logic [4:0] XZR = 5'd31;      // hard-wired zero register

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      LDSTALL = 2'b01,
      BRFLUSH = 2'b10
   } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline drives stage
// registers and control, the hazard unit returns mux selects, stall/flush
// controls, event counters and its debug state.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);

   logic [4:0]       Rn_D, Rm_D;
   logic [4:0]       Rn_E, Rm_E;
   logic [4:0]       DestinationReg_E;
   logic             MemRead_E, RegWrite_E;
   logic [4:0]       DestinationReg_M;
   logic             RegWrite_M;
   logic [4:0]       DestinationReg_W;
   logic             RegWrite_W;
   logic             PCSrc;
   logic             hold;
   logic             cnt_clr;
   logic [1:0]       ForwardA, ForwardB;
   logic             StallF, StallD;
   logic             FlushD, FlushE;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [1:0]       state_o;

   modport master (
      output Rn_D, Rm_D, Rn_E, Rm_E, DestinationReg_E, MemRead_E, RegWrite_E,
             DestinationReg_M, RegWrite_M, DestinationReg_W, RegWrite_W,
             PCSrc, hold, cnt_clr,
      input  ForwardA, ForwardB, StallF, StallD, FlushD, FlushE,
             stall_cnt, flush_cnt, state_o
   );

   modport slave (
      input  Rn_D, Rm_D, Rn_E, Rm_E, DestinationReg_E, MemRead_E, RegWrite_E,
             DestinationReg_M, RegWrite_M, DestinationReg_W, RegWrite_W,
             PCSrc, hold, cnt_clr,
      output ForwardA, ForwardB, StallF, StallD, FlushD, FlushE,
             stall_cnt, flush_cnt, state_o
   );

endinterface

// File: rtl/hazard_ctrl_forward_sel.sv
// Operand forwarding select for one execute-stage source register.
// Memory stage wins over writeback; XZR is never forwarded.
module forward_sel
   import legv8_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] dst_m,
   input  logic       wr_m,
   input  logic [4:0] dst_w,
   input  logic       wr_w,
   output logic [1:0] fwd
);

   // priority match: memory stage, then writeback, else register file
   always_comb begin
      fwd = FWD_REG;
      if (wr_m && (dst_m != XZR) && (dst_m == src)) begin
         fwd = FWD_MEM;
      end else if (wr_w && (dst_w != XZR) && (dst_w == src)) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// LEGv8 hazard unit: operand forwarding, load-use stall, taken-branch
// flush, external hold, and saturating stall/flush event counters.
module hazard_ctrl
   import legv8_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  pipe
);

   state_t           state, state_nxt;
   logic             load_use;
   logic             stall_f, stall_d, flush_d, flush_e;
   logic             inc_stall, inc_flush;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             unused_regwrite_e;

   assign unused_regwrite_e = pipe.RegWrite_E;

   forward_sel u_fwd_a (
      .src   (pipe.Rn_E),
      .dst_m (pipe.DestinationReg_M),
      .wr_m  (pipe.RegWrite_M),
      .dst_w (pipe.DestinationReg_W),
      .wr_w  (pipe.RegWrite_W),
      .fwd   (fwd_a)
   );

   forward_sel u_fwd_b (
      .src   (pipe.Rm_E),
      .dst_m (pipe.DestinationReg_M),
      .wr_m  (pipe.RegWrite_M),
      .dst_w (pipe.DestinationReg_W),
      .wr_w  (pipe.RegWrite_W),
      .fwd   (fwd_b)
   );

   assign load_use = pipe.MemRead_E && (pipe.DestinationReg_E != XZR) &&
                     ((pipe.DestinationReg_E == pipe.Rn_D) ||
                      (pipe.DestinationReg_E == pipe.Rm_D));

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= state_nxt;
   end

   // next state and stall/flush controls; the illegal code falls into RUN
   always_comb begin
      state_nxt = RUN;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      inc_stall = 1'b0;
      inc_flush = 1'b0;
      if (pipe.hold) begin
         state_nxt = state;
         stall_f   = 1'b1;
         stall_d   = 1'b1;
      end else begin
         case (state)
            LDSTALL, BRFLUSH: begin
               if (pipe.PCSrc) begin
                  flush_d   = 1'b1;
                  flush_e   = 1'b1;
                  inc_flush = 1'b1;
                  state_nxt = BRFLUSH;
               end
            end
            default: begin
               if (pipe.PCSrc) begin
                  flush_d   = 1'b1;
                  flush_e   = 1'b1;
                  inc_flush = 1'b1;
                  state_nxt = BRFLUSH;
               end else if (load_use) begin
                  stall_f   = 1'b1;
                  stall_d   = 1'b1;
                  flush_e   = 1'b1;
                  inc_stall = 1'b1;
                  state_nxt = LDSTALL;
               end
            end
         endcase
      end
   end

   // load-use stall counter: clear beats increment, saturates at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (!pipe.hold) begin
         if (pipe.cnt_clr)                        stall_cnt <= '0;
         else if (inc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // branch flush counter: clear beats increment, saturates at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flush_cnt <= '0;
      end else if (!pipe.hold) begin
         if (pipe.cnt_clr)                        flush_cnt <= '0;
         else if (inc_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   // outputs forced quiet while reset is low, even if hold/PCSrc are active
   assign pipe.ForwardA  = reset ? fwd_a : FWD_REG;
   assign pipe.ForwardB  = reset ? fwd_b : FWD_REG;
   assign pipe.StallF    = reset & stall_f;
   assign pipe.StallD    = reset & stall_d;
   assign pipe.FlushD    = reset & flush_d;
   assign pipe.FlushE    = reset & flush_e;
   assign pipe.stall_cnt = stall_cnt;
   assign pipe.flush_cnt = flush_cnt;
   assign pipe.state_o   = state;

endmodule
